// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console sequencer.
// Geometry is fixed at 4 rows x 16 columns (64 cells, 6-bit cell address).
package text_console_pkg;

  localparam int unsigned COLS      = 16;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned CELLS     = COLS * ROWS;
  localparam int unsigned COL_BITS  = 4;
  localparam int unsigned ROW_BITS  = 2;
  localparam int unsigned ADDR_BITS = COL_BITS + ROW_BITS;

  localparam logic [ADDR_BITS-1:0] ROW_STEP      = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_CELL     = ADDR_BITS'(CELLS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ROW_BASE = ADDR_BITS'(CELLS - COLS);
  localparam logic [ADDR_BITS-1:0] SCROLL_END    = ADDR_BITS'(CELLS - COLS - 1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW      = ROW_BITS'(ROWS - 1);

  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_RANGE,
    ST_SCROLL
  } state_t;

  function automatic logic isPrintable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/console_shadow_ram.sv
// 64x8 shadow of the engine's character memory: one synchronous write port,
// one asynchronous read port. Only instantiated when scrolling is enabled.
module console_shadow_ram
  import text_console_pkg::*;
(
  input  logic                 clk,
  input  logic                 writeEn,
  input  logic [ADDR_BITS-1:0] writeAddr,
  input  logic [7:0]           writeData,
  input  logic [ADDR_BITS-1:0] readAddr,
  output logic [7:0]           readData
);

  logic [7:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  assign readData = mem[readAddr];

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal-style byte sequencer driving the 64-cell text engine write port.
// Define TEXT_CONSOLE_SCROLL_EN to scroll on last-row line feed instead of wrapping.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic [ADDR_BITS-1:0] char_write_addr,
  output logic [7:0]           char_write,
  output logic                 wen,
  output logic                 ren,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] cursor_pos
);

  state_t               state, stateNext;
  logic [ADDR_BITS-1:0] cursor, cursorNext;
  logic [ADDR_BITS-1:0] clrAddr, clrAddrNext;
  logic [ADDR_BITS-1:0] clrHi, clrHiNext;
  logic [ADDR_BITS-1:0] addrNext;
  logic [7:0]           dataNext;
  logic                 wenNext, sReadyNext, busyNext;
  logic                 accept, lineFeed;
  logic [ROW_BITS-1:0]  nextRow;

  assign accept     = s_valid && s_ready;
  assign nextRow    = cursor[ADDR_BITS-1:COL_BITS] + 1'b1;
  assign ren        = 1'b0;
  assign cursor_pos = cursor;

`ifdef TEXT_CONSOLE_SCROLL_EN
  logic [7:0] shadowData;

  // Fed from the registered write port so the shadow sees exactly what the engine sees.
  console_shadow_ram u_shadow (
    .clk       (clk),
    .writeEn   (wen),
    .writeAddr (char_write_addr),
    .writeData (char_write),
    .readAddr  (clrAddr + ROW_STEP),
    .readData  (shadowData)
  );
`endif

  always_comb begin
    stateNext   = state;
    cursorNext  = cursor;
    clrAddrNext = clrAddr;
    clrHiNext   = clrHi;
    wenNext     = 1'b0;
    addrNext    = char_write_addr;
    dataNext    = char_write;
    lineFeed    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (isPrintable(s_data)) begin
            wenNext    = 1'b1;
            addrNext   = cursor;
            dataNext   = s_data;
            cursorNext = cursor + 1'b1;
            lineFeed   = (cursor == LAST_CELL);
          end else begin
            case (s_data)
              CC_LF: lineFeed = 1'b1;
              CC_CR: cursorNext = {cursor[ADDR_BITS-1:COL_BITS], {COL_BITS{1'b0}}};
              CC_BS: begin
                if (cursor != '0) begin
                  cursorNext = cursor - 1'b1;
                  wenNext    = 1'b1;
                  addrNext   = cursor - 1'b1;
                  dataNext   = CLEAR_CHAR;
                end
              end
              CC_FF: begin
                cursorNext  = '0;
                clrAddrNext = '0;
                clrHiNext   = LAST_CELL;
                stateNext   = ST_CLR_RANGE;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLR_RANGE: begin
        wenNext     = 1'b1;
        addrNext    = clrAddr;
        dataNext    = CLEAR_CHAR;
        clrAddrNext = clrAddr + 1'b1;
        if (clrAddr == clrHi) begin
          stateNext = ST_IDLE;
        end
      end
      ST_SCROLL: begin
`ifdef TEXT_CONSOLE_SCROLL_EN
        // Copy cell (dst + one row) down to dst; flows straight into clearing the last row.
        wenNext     = 1'b1;
        addrNext    = clrAddr;
        dataNext    = shadowData;
        clrAddrNext = clrAddr + 1'b1;
        if (clrAddr == SCROLL_END) begin
          clrHiNext = LAST_CELL;
          stateNext = ST_CLR_RANGE;
        end
`else
        stateNext = ST_IDLE;
`endif
      end
      default: stateNext = ST_IDLE;
    endcase

    if (lineFeed) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
      if (cursor[ADDR_BITS-1:COL_BITS] == LAST_ROW) begin
        cursorNext  = LAST_ROW_BASE;
        clrAddrNext = '0;
        stateNext   = ST_SCROLL;
      end else
`endif
      begin
        cursorNext  = {nextRow, {COL_BITS{1'b0}}};
        clrAddrNext = {nextRow, {COL_BITS{1'b0}}};
        clrHiNext   = {nextRow, {COL_BITS{1'b1}}};
        stateNext   = ST_CLR_RANGE;
      end
    end

    // One-cycle ready bubble after every accepted byte.
    sReadyNext = (stateNext == ST_IDLE) && !accept;
    busyNext   = (stateNext != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_CLR_RANGE;
      cursor          <= '0;
      clrAddr         <= '0;
      clrHi           <= LAST_CELL;
      wen             <= 1'b0;
      char_write_addr <= '0;
      char_write      <= CLEAR_CHAR;
      s_ready         <= 1'b0;
      busy            <= 1'b1;
    end else begin
      state           <= stateNext;
      cursor          <= cursorNext;
      clrAddr         <= clrAddrNext;
      clrHi           <= clrHiNext;
      wen             <= wenNext;
      char_write_addr <= addrNext;
      char_write      <= dataNext;
      s_ready         <= sReadyNext;
      busy            <= busyNext;
    end
  end

endmodule
